// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI pins plus parallel load/receive handshake of one slave.
// Revision : 1.0
// ============================================================================
interface spi_slave_if #(
  parameter int BITS = 20
);
  logic            i_sclk;
  logic            i_mosi;
  logic [2:0]      i_ss;
  logic            o_miso;
  logic [BITS-1:0] i_data;
  logic            i_load;
  logic [BITS-1:0] o_data;
  logic            o_valid;
  logic            o_busy;
  logic            o_err;

  modport slave (
    input  i_sclk, i_mosi, i_ss, i_data, i_load,
    output o_miso, o_data, o_valid, o_busy, o_err
  );

  modport master (
    output i_sclk, i_mosi, i_ss, i_data, i_load,
    input  o_miso, o_data, o_valid, o_busy, o_err
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Oversampled SPI mode-0 slave with encoded select and frame abort.
// Revision : 1.0
// ============================================================================
module spi_slave #(
  parameter int         BITS     = 20,
  parameter logic [2:0] SLAVE_ID = 3'd1
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst,
  spi_slave_if.slave bus
);

  localparam int             c_cw   = $clog2(BITS) + 1;
  localparam logic [c_cw-1:0] c_bits = c_cw'(BITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_sclk_sync;
  logic [1:0]      r_mosi_sync;
  logic [2:0]      r_ss_sync0;
  logic [2:0]      r_ss_sync1;
  logic [BITS-1:0] r_shift_in;
  logic [BITS-1:0] r_shift_out;
  logic [BITS-1:0] r_tx_buf;
  logic [BITS-1:0] r_data;
  logic [c_cw-1:0] r_cnt;
  logic            r_valid;
  logic            r_err;

  logic w_sel;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_capture;
  logic w_abort;
  logic w_shift_in;
  logic w_shift_out;

  // Addresses 0 and 7 are reserved and never select a slave.
  assign w_sel  = (r_ss_sync1 == SLAVE_ID) && (SLAVE_ID != 3'd0) && (SLAVE_ID != 3'd7);
  assign w_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_fall = ~r_sclk_sync[1] & r_sclk_sync[2];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync0  <= '0;
      r_ss_sync1  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.i_sclk};
      r_mosi_sync <= {r_mosi_sync[0], bus.i_mosi};
      r_ss_sync0  <= bus.i_ss;
      r_ss_sync1  <= r_ss_sync0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_next  = S_ACTIVE;
          w_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        // A rise coinciding with deselect falls into the abort branch and is dropped.
        if (r_cnt == c_bits) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (!w_sel) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_shift_in  = w_rise;
          w_shift_out = w_fall;
        end
      end
      S_DONE: begin
        if (!w_sel) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_tx_buf    <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= w_capture;
      r_err   <= w_abort;

      // Frame start consumes the buffer; a same-cycle load goes straight to the wire.
      if (w_start)          r_tx_buf <= '0;
      else if (bus.i_load)  r_tx_buf <= bus.i_data;

      if (w_start) begin
        r_cnt       <= '0;
        r_shift_in  <= '0;
        r_shift_out <= bus.i_load ? bus.i_data : r_tx_buf;
      end else begin
        if (w_shift_in) begin
          r_shift_in <= {r_shift_in[BITS-2:0], r_mosi_sync[1]};
          r_cnt      <= r_cnt + c_cw'(1);
        end
        if (w_shift_out) r_shift_out <= {r_shift_out[BITS-2:0], 1'b0};
      end

      if (w_capture) r_data <= r_shift_in;
    end
  end

  assign bus.o_miso  = (r_state == S_ACTIVE) & r_shift_out[BITS-1];
  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_busy  = (r_state != S_IDLE);
  assign bus.o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Directed vector bench for spi_slave (BITS=20, SLAVE_ID=1).
// Revision : 1.0
// ============================================================================
module tb_spi_slave;

  localparam int BITS = 20;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  spi_slave_if #(.BITS(BITS)) bus ();

  spi_slave #(.BITS(BITS), .SLAVE_ID(3'd1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  bit busy_seen = 1'b0;

  always @(negedge i_clk) begin
    if (bus.o_valid) n_valid++;
    if (bus.o_err)   n_err++;
    if (bus.o_busy)  busy_seen = 1'b1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          pre_ld;
    logic [19:0] pre_word;
    bit          st_ld;
    logic [19:0] st_word;
    logic [2:0]  ss;
    logic [19:0] mosi;
    int          nbits;
    logic [19:0] exp_data;
    int          exp_valid;
    int          exp_err;
    logic [19:0] exp_miso;
    bit          exp_busy;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_load(input logic [19:0] w);
    bus.i_load = 1'b1;
    bus.i_data = w;
    wait_cyc(1);
    bus.i_load = 1'b0;
  endtask

  // Master side: 4-cycle sclk phases, MISO sampled just before each rise.
  task automatic run_frame(input logic [2:0] ss, input logic [19:0] mosi, input int nbits,
                           input bit st_ld, input logic [19:0] st_word,
                           input int mid_at, input logic [19:0] mid_word,
                           input int rst_at, output logic [19:0] miso_cap);
    logic [19:0] sh;
    n_valid   = 0;
    n_err     = 0;
    busy_seen = 1'b0;
    miso_cap  = '0;
    sh        = mosi;
    bus.i_mosi = sh[BITS-1];
    bus.i_ss   = ss;
    wait_cyc(2);
    if (st_ld) begin
      pulse_load(st_word);
      wait_cyc(1);
    end else begin
      wait_cyc(2);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        i_rst = 1'b0;
        #1;
        check("rst_busy",  {63'd0, bus.o_busy},  64'd0);
        check("rst_miso",  {63'd0, bus.o_miso},  64'd0);
        check("rst_valid", {63'd0, bus.o_valid}, 64'd0);
        check("rst_err",   {63'd0, bus.o_err},   64'd0);
        check("rst_data",  {44'd0, bus.o_data},  64'd0);
        bus.i_ss   = 3'd7;
        bus.i_sclk = 1'b0;
        wait_cyc(3);
        i_rst = 1'b1;
        wait_cyc(6);
        return;
      end
      miso_cap   = {miso_cap[18:0], bus.o_miso};
      bus.i_sclk = 1'b1;
      if (i == mid_at) begin
        pulse_load(mid_word);
        wait_cyc(3);
      end else begin
        wait_cyc(4);
      end
      bus.i_sclk = 1'b0;
      sh         = sh << 1;
      bus.i_mosi = sh[BITS-1];
      wait_cyc(4);
    end
    wait_cyc(2);
    bus.i_ss = 3'd7;
    wait_cyc(6);
  endtask

  task automatic frame_checks(input string tag, input logic [19:0] cap, input logic [19:0] exp_data,
                              input int exp_valid, input int exp_err, input logic [19:0] exp_miso,
                              input bit exp_busy);
    check({tag, "_data"},  {44'd0, bus.o_data}, {44'd0, exp_data});
    check({tag, "_valid"}, 64'(n_valid), 64'(exp_valid));
    check({tag, "_err"},   64'(n_err), 64'(exp_err));
    check({tag, "_miso"},  {44'd0, cap}, {44'd0, exp_miso});
    check({tag, "_busy"},  {63'd0, busy_seen}, {63'd0, exp_busy});
    check({tag, "_idle"},  {63'd0, bus.o_busy}, 64'd0);
  endtask

  initial begin
    logic [19:0] cap;

    //         pre  pre_word   st  st_word    ss    mosi       n   data       v  e  miso       busy
    vec[0] = '{1'b1, 20'hA5F0F, 1'b0, 20'h0,     3'd1, 20'h3C3C3, 20, 20'h3C3C3, 1, 0, 20'hA5F0F, 1'b1};
    vec[1] = '{1'b0, 20'h0,     1'b0, 20'h0,     3'd1, 20'hABCDE, 20, 20'hABCDE, 1, 0, 20'h00000, 1'b1};
    vec[2] = '{1'b1, 20'hFFFFF, 1'b0, 20'h0,     3'd2, 20'h12345, 20, 20'hABCDE, 0, 0, 20'h00000, 1'b0};
    vec[3] = '{1'b0, 20'h0,     1'b0, 20'h0,     3'd1, 20'h55555,  7, 20'hABCDE, 0, 1, 20'h0007F, 1'b1};
    vec[4] = '{1'b0, 20'h0,     1'b0, 20'h0,     3'd1, 20'h0F0F0, 20, 20'h0F0F0, 1, 0, 20'h00000, 1'b1};
    vec[5] = '{1'b1, 20'h80001, 1'b0, 20'h0,     3'd1, 20'hFFFFF, 20, 20'hFFFFF, 1, 0, 20'h80001, 1'b1};
    vec[6] = '{1'b1, 20'h22222, 1'b1, 20'h3ABCD, 3'd1, 20'h00001, 20, 20'h00001, 1, 0, 20'h3ABCD, 1'b1};
    vec[7] = '{1'b0, 20'h0,     1'b0, 20'h0,     3'd1, 20'h96C3A, 20, 20'h96C3A, 1, 0, 20'h00000, 1'b1};

    bus.i_sclk = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_ss   = 3'd7;
    bus.i_data = '0;
    bus.i_load = 1'b0;
    wait_cyc(3);
    check("reset_data",  {44'd0, bus.o_data},  64'd0);
    check("reset_valid", {63'd0, bus.o_valid}, 64'd0);
    check("reset_busy",  {63'd0, bus.o_busy},  64'd0);
    check("reset_err",   {63'd0, bus.o_err},   64'd0);
    check("reset_miso",  {63'd0, bus.o_miso},  64'd0);
    i_rst = 1'b1;
    wait_cyc(3);

    for (int i = 0; i < 8; i++) begin
      if (vec[i].pre_ld) pulse_load(vec[i].pre_word);
      run_frame(vec[i].ss, vec[i].mosi, vec[i].nbits, vec[i].st_ld, vec[i].st_word,
                -1, 20'h0, -1, cap);
      frame_checks($sformatf("vec%0d", i), cap, vec[i].exp_data, vec[i].exp_valid,
                   vec[i].exp_err, vec[i].exp_miso, vec[i].exp_busy);
    end

    // Load during a frame only affects the following frame.
    pulse_load(20'hC0FFE);
    run_frame(3'd1, 20'h13579, 20, 1'b0, 20'h0, 10, 20'h12345, -1, cap);
    frame_checks("midload_a", cap, 20'h13579, 1, 0, 20'hC0FFE, 1'b1);
    run_frame(3'd1, 20'h2468A, 20, 1'b0, 20'h0, -1, 20'h0, -1, cap);
    frame_checks("midload_b", cap, 20'h2468A, 1, 0, 20'h12345, 1'b1);

    // Reset after 10 bits clears everything, then a clean frame follows.
    pulse_load(20'h77777);
    run_frame(3'd1, 20'h5A5A5, 20, 1'b0, 20'h0, -1, 20'h0, 10, cap);
    check("rstframe_valid", 64'(n_valid), 64'd0);
    check("rstframe_err",   64'(n_err),   64'd0);
    check("rstframe_data",  {44'd0, bus.o_data}, 64'd0);
    check("rstframe_idle",  {63'd0, bus.o_busy}, 64'd0);
    run_frame(3'd1, 20'h6B6B6, 20, 1'b0, 20'h0, -1, 20'h0, -1, cap);
    frame_checks("postrst", cap, 20'h6B6B6, 1, 0, 20'h00000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter BITS, default 20, frame length in bits (2..64).
REQ-002 Parameter SLAVE_ID, default 1, 3-bit address this slave answers to (1..6; 0 and 7 never match).
REQ-003 i_clk  input  1  system clock; all state updates on its rising edge; the block uses one clock.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_sclk  input  1  serial clock from master; idles low; asynchronous to i_clk.
REQ-006 i_mosi  input  1  serial data from master; asynchronous.
REQ-007 i_ss  input  3  encoded slave select; 3'b111 = idle; selected when i_ss == SLAVE_ID.
REQ-008 o_miso  output  1  serial data to master.
REQ-009 i_data  input  BITS  response word for the next frame.
REQ-010 i_load  input  1  one-cycle strobe capturing i_data into the transmit buffer.
REQ-011 o_data  output  BITS  last complete received word.
REQ-012 o_valid  output  1  one-cycle pulse: o_data updated.
REQ-013 o_busy  output  1  high while a frame is in progress.
REQ-014 o_err  output  1  one-cycle pulse: frame aborted before BITS bits.

Function
REQ-015 i_sclk, i_mosi and i_ss each pass through a 2-flop synchronizer; i_sclk gets a third flop for edge detection.
REQ-016 Operating constraint: every i_sclk high and low phase lasts at least 3 i_clk cycles; i_ss is stable for at least 3 i_clk cycles before the first rising edge of i_sclk.
REQ-017 "sel" = synchronized i_ss == SLAVE_ID; rise/fall = synchronized i_sclk 0->1 / 1->0.
REQ-018 FSM states: IDLE, ACTIVE, DONE.
REQ-019 IDLE: o_busy=0; on sel -> ACTIVE, clear the bit counter, copy the transmit buffer to the shift-out register; i_sclk edges while not selected are ignored.
REQ-020 ACTIVE: o_busy=1; on rise, shift the synchronized i_mosi into the LSB of the shift-in register (MSB first) and increment the bit counter.
REQ-021 ACTIVE: on fall, shift the shift-out register left by one; o_miso = shift-out MSB, so bit BITS-1 is present before the first rise.
REQ-022 ACTIVE -> DONE when the counter reaches BITS; on the same cycle o_data <= shift-in register and o_valid = 1 for one cycle.
REQ-023 ACTIVE with sel deasserted and counter < BITS -> IDLE, o_err = 1 for one cycle, o_data unchanged, no o_valid.
REQ-024 DONE: o_busy=1; further edges are ignored (shift registers frozen); -> IDLE when sel deasserts.
REQ-025 o_miso = 0 whenever the state is not ACTIVE.
REQ-026 i_load is accepted in any state; it writes only the transmit buffer, so a load during a frame takes effect on the next frame.
REQ-027 If the transmit buffer has not been loaded since the previous frame started, the next frame transmits all zeros (buffer cleared on frame start).
REQ-028 i_load on the same cycle as the IDLE->ACTIVE transition: the new i_data is transmitted in this frame.
REQ-029 A rise in the same cycle that sel deasserts is discarded; the abort rule of REQ-023 applies.
REQ-030 Counter width is $clog2(BITS)+1; no wrap-around within a frame.

Reset
REQ-031 While i_rst=0: state IDLE, all synchronizers, shift registers, counter, transmit buffer and o_data = 0; o_miso, o_valid, o_busy, o_err = 0.
REQ-032 Reset asserted mid-frame aborts the frame immediately with no o_valid or o_err pulse; after release the block waits in IDLE for a new sel.

Verification
REQ-033 BITS=20, SLAVE_ID=1: i_load with 20'hA5F0F; master sends 20'h3C3C3 with i_ss=1 and 4-cycle sclk phases -> o_data=20'h3C3C3, one o_valid pulse, MISO bits = 20'hA5F0F MSB first.
REQ-034 Back-to-back frames with no i_load between them -> the second frame sends all zeros on MISO and its o_data is correct.
REQ-035 i_ss=2 with a full clock burst -> o_busy stays 0, o_miso stays 0, no o_valid, o_data unchanged.
REQ-036 i_ss returns to 7 after 7 bits -> o_err pulses once, no o_valid, next full frame is received correctly.
REQ-037 i_load of 20'h12345 mid-frame -> current MISO data unaffected; next frame transmits 20'h12345.
REQ-038 i_rst low after 10 bits -> all outputs 0 at once; the following complete frame gives the correct o_data.
